// File: rtl/reg_file_mp.sv
// Multi-port integer register file: combinational reads with optional write bypass,
// prioritised multi-port writes, x0 hardwired to zero, and a sequential array clear.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*AW-1:0]       i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_dat,
    input  logic [NUM_WR*AW-1:0]       i_wr_addr,
    input  logic [NUM_WR-1:0]          i_wr_en,
    input  logic [NUM_WR*DATA_W-1:0]   i_wr_dat,
    input  logic                       i_clr,
    output logic                       o_clr_busy,
    output logic                       o_clr_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    logic [AW-1:0]       ptr;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                last_c;

    assign last_c = (ptr == AW'(NUM_REGS - 1));

    // Clear sequencer; done is raised one edge early so it coincides with the last clear cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= AW'(1);
            o_clr_busy <= 1'b0;
            o_clr_done <= 1'b0;
        end else begin
            o_clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_clr) begin
                        state      <= CLEAR;
                        ptr        <= AW'(1);
                        o_clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(NUM_REGS - 2)) begin
                        o_clr_done <= 1'b1;
                    end
                    if (last_c) begin
                        state      <= IDLE;
                        ptr        <= AW'(1);
                        o_clr_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array update: later ports overwrite earlier ones, so the highest index wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[ptr] <= '0;
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] != '0)) begin
                    regs[i_wr_addr[w*AW +: AW]] <= i_wr_dat[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read ports with same-cycle forwarding, suppressed while clearing
    always_comb begin
        o_rd_dat = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            o_rd_dat[p*DATA_W +: DATA_W] = regs[i_rd_addr[p*AW +: AW]];
            if ((BYPASS != 0) && (state == IDLE)) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == i_rd_addr[p*AW +: AW])) begin
                        o_rd_dat[p*DATA_W +: DATA_W] = i_wr_dat[w*DATA_W +: DATA_W];
                    end
                end
            end
            if (i_rd_addr[p*AW +: AW] == '0) begin
                o_rd_dat[p*DATA_W +: DATA_W] = '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: bypass and non-bypass instances share stimulus; expectations are
// queued as stimulus is applied and drained against the outputs before the next edge.
module tb_reg_file_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_dat;
    logic [2*DW-1:0] rd_dat_nb;
    logic [2*AW-1:0] wr_addr;
    logic [1:0]      wr_en;
    logic [2*DW-1:0] wr_dat;
    logic            clr;
    logic            busy, done, busy_nb, done_nb;

    int n_checks = 0;
    int n_fail   = 0;

    int          sel_q  [$];
    logic [31:0] exp_q  [$];
    string       name_q [$];

    typedef struct {
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] n0;
        logic [31:0] n1;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .i_rd_addr(rd_addr), .o_rd_dat(rd_dat),
        .i_wr_addr(wr_addr), .i_wr_en(wr_en), .i_wr_dat(wr_dat),
        .i_clr(clr), .o_clr_busy(busy), .o_clr_done(done)
    );

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .i_rd_addr(rd_addr), .o_rd_dat(rd_dat_nb),
        .i_wr_addr(wr_addr), .i_wr_en(wr_en), .i_wr_dat(wr_dat),
        .i_clr(clr), .o_clr_busy(busy_nb), .o_clr_done(done_nb)
    );

    function automatic logic [31:0] fill(input int k);
        return 32'hA500_0000 | 32'(k);
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return rd_dat[31:0];
            1:       return rd_dat[63:32];
            2:       return rd_dat_nb[31:0];
            3:       return rd_dat_nb[63:32];
            4:       return {31'd0, busy};
            5:       return {31'd0, done};
            6:       return {31'd0, busy_nb};
            default: return {31'd0, done_nb};
        endcase
    endfunction

    task automatic push(input int sel, input logic [31:0] e, input string nm);
        sel_q.push_back(sel);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic exp_rd(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] n0, input logic [31:0] n1);
        push(0, e0, {nm, ".rd0"});
        push(1, e1, {nm, ".rd1"});
        push(2, n0, {nm, ".nb_rd0"});
        push(3, n1, {nm, ".nb_rd1"});
    endtask

    task automatic exp_ctl(input string nm, input logic b, input logic d);
        push(4, {31'd0, b}, {nm, ".busy"});
        push(5, {31'd0, d}, {nm, ".done"});
        push(6, {31'd0, b}, {nm, ".nb_busy"});
        push(7, {31'd0, d}, {nm, ".nb_done"});
    endtask

    task automatic check_q();
        while (sel_q.size() > 0) begin
            int          s;
            logic [31:0] e;
            logic [31:0] a;
            string       nm;
            s  = sel_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = actual(s);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", nm, a, e);
            end
        end
    endtask

    task automatic set_in(input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] we,
                          input logic [4:0] wa0, input logic [31:0] wd0,
                          input logic [4:0] wa1, input logic [31:0] wd1);
        rd_addr = {ra1, ra0};
        wr_en   = we;
        wr_addr = {wa1, wa0};
        wr_dat  = {wd1, wd0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'd5, 5'd6, 2'b11, 5'd5, 32'h12345678, 5'd6, 32'hCAFEBABE,
                     32'h12345678, 32'hCAFEBABE, 32'h0, 32'h0};
        vecs[1]  = '{5'd5, 5'd6, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                     32'h12345678, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE};
        vecs[2]  = '{5'd7, 5'd7, 2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222,
                     32'h22222222, 32'h22222222, 32'h0, 32'h0};
        vecs[3]  = '{5'd7, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                     32'h22222222, 32'h0, 32'h22222222, 32'h0};
        vecs[4]  = '{5'd0, 5'd0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF,
                     32'h0, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{5'd0, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                     32'h0, 32'h12345678, 32'h0, 32'h12345678};
        vecs[6]  = '{5'd5, 5'd6, 2'b01, 5'd5, 32'hAAAA0005, 5'd6, 32'hEEEEEEEE,
                     32'hAAAA0005, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE};
        vecs[7]  = '{5'd5, 5'd6, 2'b10, 5'd5, 32'hEEEEEEEE, 5'd6, 32'hBBBB0006,
                     32'hAAAA0005, 32'hBBBB0006, 32'hAAAA0005, 32'hCAFEBABE};
        vecs[8]  = '{5'd6, 5'd7, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                     32'hBBBB0006, 32'h22222222, 32'hBBBB0006, 32'h22222222};
        vecs[9]  = '{5'd9, 5'd8, 2'b11, 5'd8, 32'h80808080, 5'd9, 32'h90909090,
                     32'h90909090, 32'h80808080, 32'h0, 32'h0};
        vecs[10] = '{5'd8, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                     32'h80808080, 32'h90909090, 32'h80808080, 32'h90909090};
        vecs[11] = '{5'd7, 5'd7, 2'b11, 5'd7, 32'h33333333, 5'd0, 32'h44444444,
                     32'h33333333, 32'h33333333, 32'h22222222, 32'h22222222};
        vecs[12] = '{5'd7, 5'd10, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                     32'h33333333, 32'h0, 32'h33333333, 32'h0};

        // reset state: every address reads zero on both ports
        rst = 1'b0;
        clr = 1'b0;
        set_in(5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #2;
        for (int a = 0; a < 32; a += 2) begin
            set_in(5'(a), 5'(a + 1), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            #1;
            exp_rd("reset", 32'h0, 32'h0, 32'h0, 32'h0);
            check_q();
        end
        exp_ctl("reset", 1'b0, 1'b0);
        check_q();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // table-driven read/write/bypass/priority vectors
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].ra0, vecs[i].ra1, vecs[i].we, vecs[i].wa0, vecs[i].wd0,
                   vecs[i].wa1, vecs[i].wd1);
            exp_rd($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].n0, vecs[i].n1);
            exp_ctl($sformatf("vec%0d", i), 1'b0, 1'b0);
            @(negedge clk);
            check_q();
            next_cycle();
        end

        // full clear: fill x1..x31, then clear while hammering the write ports
        for (int k = 1; k < 32; k++) begin
            set_in(5'd0, 5'd0, 2'b01, 5'(k), fill(k), 5'd0, 32'h0);
            next_cycle();
        end
        set_in(5'd31, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        clr = 1'b1;
        exp_rd("pre_clear", fill(31), fill(1), fill(31), fill(1));
        exp_ctl("clr_req", 1'b0, 1'b0);
        @(negedge clk);
        check_q();
        next_cycle();
        clr = 1'b0;
        for (int k = 1; k < 32; k++) begin
            set_in(5'(k), 5'(k - 1), 2'b11, 5'(k), 32'hFFFF0000, 5'd3, 32'h33333333);
            clr = (k == 5);
            exp_rd($sformatf("clr%0d", k), fill(k), 32'h0, fill(k), 32'h0);
            exp_ctl($sformatf("clr%0d", k), 1'b1, k == 31);
            @(negedge clk);
            check_q();
            next_cycle();
        end
        clr = 1'b0;
        set_in(5'd3, 5'd31, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        exp_rd("post_clear", 32'h0, 32'h0, 32'h0, 32'h0);
        exp_ctl("post_clear", 1'b0, 1'b0);
        @(negedge clk);
        check_q();
        for (int a = 0; a < 32; a += 2) begin
            set_in(5'(a), 5'(a + 1), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            #1;
            exp_rd($sformatf("cleared%0d", a), 32'h0, 32'h0, 32'h0, 32'h0);
            check_q();
        end
        next_cycle();

        // reset in the middle of a clear
        set_in(5'd0, 5'd0, 2'b11, 5'd4, 32'h44444444, 5'd20, 32'h20202020);
        next_cycle();
        set_in(5'd20, 5'd4, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        for (int k = 1; k < 10; k++) begin
            next_cycle();
        end
        exp_rd("mid_clear", 32'h20202020, 32'h0, 32'h20202020, 32'h0);
        exp_ctl("mid_clear", 1'b1, 1'b0);
        check_q();
        rst = 1'b0;
        #1;
        exp_rd("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        exp_ctl("async_rst", 1'b0, 1'b0);
        check_q();
        #2;
        rst = 1'b1;
        next_cycle();
        set_in(5'd9, 5'd20, 2'b01, 5'd9, 32'hDEADBEEF, 5'd0, 32'h0);
        exp_rd("after_rst_wr", 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
        exp_ctl("after_rst_wr", 1'b0, 1'b0);
        @(negedge clk);
        check_q();
        next_cycle();
        set_in(5'd9, 5'd20, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        exp_rd("after_rst_rd", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);
        exp_ctl("after_rst_rd", 1'b0, 1'b0);
        @(negedge clk);
        check_q();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
